// File: rtl/xosera_pkg.sv
// Shared types for the colormem write path.
// Grant encoding and fill FSM states.
package xosera_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_COP,
    GRANT_FILL,
    GRANT_HOST
  } colormem_grant_t;

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } fill_state_t;

endpackage

// File: rtl/colormem_fill.sv
// Range-fill sequencer for the colormem write port.
// Requests one write per cycle from base until count runs out.
import xosera_pkg::*;

module colormem_fill #(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] base_i,
  input  logic [AWIDTH:0]   count_i,
  input  word_t             data_i,
  input  logic              grant_i,
  output logic              req_o,
  output logic [AWIDTH-1:0] addr_o,
  output word_t             data_o,
  output logic              busy_o
);

  fill_state_t       state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH:0]   cnt_q, cnt_d;
  word_t             data_q, data_d;

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // next state: start only from idle, leave on the last grant
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && (count_i != '0)) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (grant_i && (cnt_q == 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // latch the range at start, advance address/count per grant
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    if (state_q == ST_IDLE) begin
      if (start_i) begin
        addr_d = base_i;
        cnt_d  = count_i;
        data_d = data_i;
      end
    end else if (grant_i) begin
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
    end
  end

  // outputs decode directly from the state register
  always_comb begin
    req_o  = (state_q == ST_FILL);
    busy_o = (state_q == ST_FILL);
    addr_o = addr_q;
    data_o = data_q;
  end

endmodule

// File: rtl/colormem_wr_arb.sv
// Colormem write-port arbiter: copper > fill > host with host starvation guard.
// Fill sequencer built only when COLORMEM_FILL_EN is defined.
import xosera_pkg::*;

module colormem_wr_arb #(
  parameter int AWIDTH        = 8,
  parameter int HOST_WAIT_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              cop_req_i,
  input  logic [AWIDTH-1:0] cop_addr_i,
  input  word_t             cop_data_i,
  output logic              cop_ack_o,
  input  logic              host_req_i,
  input  logic [AWIDTH-1:0] host_addr_i,
  input  word_t             host_data_i,
  output logic              host_ack_o,
  input  logic              fill_start_i,
  input  logic [AWIDTH-1:0] fill_base_i,
  input  logic [AWIDTH:0]   fill_count_i,
  input  word_t             fill_data_i,
  output logic              fill_busy_o,
  output logic              wr_en_o,
  output logic [AWIDTH-1:0] wr_address_o,
  output word_t             wr_data_o
);

  localparam int WW =
    (HOST_WAIT_MAX > 0) ? $clog2(HOST_WAIT_MAX + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(HOST_WAIT_MAX);

  colormem_grant_t   grant;
  logic              host_force;
  logic [WW-1:0]     wait_q, wait_d;
  logic              wr_en_q, wr_en_d;
  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
  word_t             wr_data_q, wr_data_d;

  logic              fill_req;
  logic [AWIDTH-1:0] fill_addr;
  word_t             fill_data;

`ifdef COLORMEM_FILL_EN
  colormem_fill #(
    .AWIDTH (AWIDTH)
  ) u_fill (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .start_i   (fill_start_i),
    .base_i    (fill_base_i),
    .count_i   (fill_count_i),
    .data_i    (fill_data_i),
    .grant_i   (grant == GRANT_FILL),
    .req_o     (fill_req),
    .addr_o    (fill_addr),
    .data_o    (fill_data),
    .busy_o    (fill_busy_o)
  );
`else
  logic unused_fill;
  assign unused_fill = ^{fill_start_i, fill_base_i,
                         fill_count_i, fill_data_i};
  assign fill_req    = 1'b0;
  assign fill_addr   = '0;
  assign fill_data   = '0;
  assign fill_busy_o = 1'b0;
`endif

  assign host_force = host_req_i && (wait_q == WAIT_MAX);

  // single grant per cycle; a starved host jumps the queue
  always_comb begin
    grant = GRANT_NONE;
    if (host_force) begin
      grant = GRANT_HOST;
    end else if (cop_req_i) begin
      grant = GRANT_COP;
    end else if (fill_req) begin
      grant = GRANT_FILL;
    end else if (host_req_i) begin
      grant = GRANT_HOST;
    end
  end

  assign cop_ack_o  = (grant == GRANT_COP);
  assign host_ack_o = (grant == GRANT_HOST);

  // count denied host cycles, saturating at the limit
  always_comb begin
    wait_d = wait_q;
    if (!host_req_i || (grant == GRANT_HOST)) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // select the granted write; address/data hold when idle
  always_comb begin
    wr_en_d   = 1'b1;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (grant)
      GRANT_COP: begin
        wr_addr_d = cop_addr_i;
        wr_data_d = cop_data_i;
      end
      GRANT_FILL: begin
        wr_addr_d = fill_addr;
        wr_data_d = fill_data;
      end
      GRANT_HOST: begin
        wr_addr_d = host_addr_i;
        wr_data_d = host_data_i;
      end
      default: wr_en_d = 1'b0;
    endcase
  end

  // registered write port and starvation counter
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wait_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wait_q    <= wait_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_address_o = wr_addr_q;
  assign wr_data_o    = wr_data_q;

endmodule

// File: tb/tb_colormem_wr_arb.sv
// Scoreboard bench for colormem_wr_arb.
// Fill scenarios expect no writes unless COLORMEM_FILL_EN is defined.
import xosera_pkg::*;

module tb_colormem_wr_arb;

  localparam int AW  = 8;
  localparam int HWM = 4;
`ifdef COLORMEM_FILL_EN
  localparam int FILL_ON = 1;
`else
  localparam int FILL_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          cop_req_i = 1'b0;
  logic [AW-1:0] cop_addr_i = '0;
  word_t         cop_data_i = '0;
  logic          cop_ack_o;
  logic          host_req_i = 1'b0;
  logic [AW-1:0] host_addr_i = '0;
  word_t         host_data_i = '0;
  logic          host_ack_o;
  logic          fill_start_i = 1'b0;
  logic [AW-1:0] fill_base_i = '0;
  logic [AW:0]   fill_count_i = '0;
  word_t         fill_data_i = '0;
  logic          fill_busy_o;
  logic          wr_en_o;
  logic [AW-1:0] wr_address_o;
  word_t         wr_data_o;

  colormem_wr_arb #(
    .AWIDTH        (AW),
    .HOST_WAIT_MAX (HWM)
  ) dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .cop_req_i    (cop_req_i),
    .cop_addr_i   (cop_addr_i),
    .cop_data_i   (cop_data_i),
    .cop_ack_o    (cop_ack_o),
    .host_req_i   (host_req_i),
    .host_addr_i  (host_addr_i),
    .host_data_i  (host_data_i),
    .host_ack_o   (host_ack_o),
    .fill_start_i (fill_start_i),
    .fill_base_i  (fill_base_i),
    .fill_count_i (fill_count_i),
    .fill_data_i  (fill_data_i),
    .fill_busy_o  (fill_busy_o),
    .wr_en_o      (wr_en_o),
    .wr_address_o (wr_address_o),
    .wr_data_o    (wr_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] shadow[256];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_wr = 0;
  int          wait_m = 0;
  int          fill_rem = 0;
  logic [AW-1:0] fill_a_m = '0;
  logic [15:0]   fill_d_m = '0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // reference model: arbitration, fill sequence, write scoreboard
  always @(negedge clk) begin
    exp_t e;
    int   g;
    int   rem0;
    if (!reset_n_i) begin
      check("rst_wren", wr_en_o, 0);
      check("rst_busy", fill_busy_o, 0);
      check("rst_acks", {cop_ack_o, host_ack_o}, 0);
      sb.delete();
      wait_m   = 0;
      fill_rem = 0;
    end else begin
      if (wr_en_o) begin
        n_wr++;
        shadow[wr_address_o] = wr_data_o;
        if (sb.size() == 0) begin
          check("spurious_wr", 1, 0);
        end else begin
          e = sb.pop_front();
          check("wr_addr", wr_address_o, e.a);
          check("wr_data", wr_data_o, e.d);
        end
      end else if (sb.size() != 0) begin
        check("missing_wr", sb.size(), 0);
        sb.delete();
      end
      rem0 = fill_rem;
      check("busy", fill_busy_o, rem0 > 0);
      if (host_req_i && wait_m == HWM) g = 3;
      else if (cop_req_i) g = 1;
      else if (rem0 > 0) g = 2;
      else if (host_req_i) g = 3;
      else g = 0;
      check("cop_ack", cop_ack_o, g == 1);
      check("host_ack", host_ack_o, g == 3);
      if (g == 1) sb.push_back('{cop_addr_i, cop_data_i});
      if (g == 3) sb.push_back('{host_addr_i, host_data_i});
      if (g == 2) begin
        sb.push_back('{fill_a_m, fill_d_m});
        fill_a_m = fill_a_m + 1'b1;
        fill_rem--;
      end
      if (!host_req_i || g == 3) wait_m = 0;
      else if (wait_m != HWM) wait_m++;
      if (FILL_ON != 0 && fill_start_i && rem0 == 0
          && fill_count_i != 0) begin
        fill_rem = int'(fill_count_i);
        fill_a_m = fill_base_i;
        fill_d_m = fill_data_i;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit cop);
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cop ? cop_ack_o : host_ack_o) break;
    end
    if (i == 50) check("ack_timeout", 0, 1);
    cyc(1);
    if (cop) cop_req_i = 1'b0;
    else host_req_i = 1'b0;
  endtask

  task automatic start_fill(input logic [AW-1:0] b,
                            input int c,
                            input logic [15:0] d);
    fill_start_i = 1'b1;
    fill_base_i  = b;
    fill_count_i = (AW+1)'(c);
    fill_data_i  = d;
    cyc(1);
    fill_start_i = 1'b0;
  endtask

  initial begin
    int w0;
    int nc;
    int nh;
    int errs;
    cyc(3);
    check("rst_addr", wr_address_o, 0);
    check("rst_data", wr_data_o, 0);
    reset_n_i = 1'b1;
    cyc(2);
    check("idle_wren", wr_en_o, 0);

    host_addr_i = 8'h10;
    host_data_i = 16'h0F0F;
    host_req_i  = 1'b1;
    wait_ack(1'b0);
    cyc(2);
    check("mem_10", shadow[8'h10], 16'h0F0F);

    cop_addr_i  = 8'h20;
    cop_data_i  = 16'h1000;
    host_addr_i = 8'h21;
    host_data_i = 16'h2000;
    cop_req_i   = 1'b1;
    host_req_i  = 1'b1;
    nc = 0;
    nh = 0;
    for (int k = 0; k < 15; k++) begin
      bit c;
      bit h;
      @(negedge clk);
      c = cop_ack_o;
      h = host_ack_o;
      nc += int'(c);
      nh += int'(h);
      check("one_ack", int'(c) + int'(h), 1);
      check("host_turn", h, (k % 5) == 4);
      cyc(1);
      if (c) cop_data_i = cop_data_i + 1'b1;
      if (h) host_data_i = host_data_i + 1'b1;
    end
    check("cop_share", nc, 12);
    check("host_share", nh, 3);
    cop_req_i  = 1'b0;
    host_req_i = 1'b0;
    cyc(3);

    w0 = n_wr;
    start_fill(8'hFE, 4, 16'h1234);
    cyc(8);
    check("fill4_cnt", n_wr - w0, 4 * FILL_ON);

    w0 = n_wr;
    start_fill(8'h30, 0, 16'hDEAD);
    cyc(5);
    check("fill0_cnt", n_wr - w0, 0);

    w0 = n_wr;
    start_fill(8'h20, 3, 16'h5555);
    cyc(1);
    start_fill(8'h40, 6, 16'h6666);
    cyc(10);
    check("refill_cnt", n_wr - w0, 3 * FILL_ON);

    w0 = n_wr;
    start_fill(8'h00, 256, 16'h1234);
    cyc(9);
    cop_addr_i = 8'h05;
    cop_data_i = 16'hBEEF;
    cop_req_i  = 1'b1;
    wait_ack(1'b1);
    for (int i = 0; i < 400 && fill_busy_o; i++) cyc(1);
    check("fill256_done", fill_busy_o, 0);
    cyc(2);
    check("fill256_cnt", n_wr - w0, 256 * FILL_ON + 1);
    check("mem_05", shadow[8'h05], 16'hBEEF);
`ifdef COLORMEM_FILL_EN
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (i != 5 && shadow[i] !== 16'h1234) errs++;
    end
    check("fill256_mem", errs, 0);

    w0 = n_wr;
    start_fill(8'h80, 8, 16'hAAAA);
    for (int i = 0; i < 50 && (n_wr - w0) < 3; i++) cyc(1);
    check("mid_progress", n_wr - w0, 3);
    reset_n_i = 1'b0;
    #1;
    check("mid_wren", wr_en_o, 0);
    check("mid_busy", fill_busy_o, 0);
    cyc(2);
    reset_n_i = 1'b1;
    w0 = n_wr;
    cyc(10);
    check("post_rst_wr", n_wr - w0, 0);
`else
    errs = 0;
`endif
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
